// File: rtl/lsu_unit.sv
// lsu_unit: memory-stage load/store unit.
// Issues one word-aligned request at a time on the dmem req/gnt/rvalid bus,
// stalls the pipeline while the transaction is in flight, and returns
// aligned, sign/zero-extended load data for write-back.
//
// state | meaning
// IDLE  | waiting for a valid, aligned load/store from the memory stage
// REQ   | dmem_req_o high, request fields held stable until grant
// WAIT  | granted, waiting for dmem_rvalid_i
// DONE  | response taken; load result presented for one cycle, pipeline released
module lsu_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m_valid_i,
  input  logic        m_is_store_i,
  input  logic [1:0]  m_size_i,
  input  logic        m_unsigned_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] m_store_data_i,
  output logic        lsu_stall_o,
  output logic        lsu_misaligned_o,
  output logic        w_load_valid_o,
  output logic [31:0] w_load_data_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] load_data_q;

  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [31:0] load_proc;
  logic        accept;
  logic        capture_load;

  // Alignment check and request-field formatting from the incoming instruction
  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = m_store_data_i;
    case (m_size_i)
      2'b00: begin
        be_in    = 4'b0001 << m_addr_i[1:0];
        wdata_in = {4{m_store_data_i[7:0]}};
      end
      2'b01: begin
        misaligned = m_addr_i[0];
        be_in      = 4'b0011 << m_addr_i[1:0];
        wdata_in   = {2{m_store_data_i[15:0]}};
      end
      2'b10: begin
        misaligned = |m_addr_i[1:0];
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Align read data to the byte offset and extend to 32 bits
  always_comb begin
    shifted = dmem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_proc = uns_q ? {24'h0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_proc = uns_q ? {16'h0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_proc = shifted;
    endcase
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    capture_load     = 1'b0;
    lsu_stall_o      = 1'b0;
    lsu_misaligned_o = 1'b0;
    dmem_req_o       = 1'b0;
    w_load_valid_o   = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_misaligned_o = m_valid_i & misaligned;
        if (m_valid_i && !misaligned) begin
          accept      = 1'b1;
          lsu_stall_o = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        lsu_stall_o = 1'b1;
        dmem_req_o  = 1'b1;
        if (dmem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        lsu_stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          capture_load = ~we_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        // m_valid_i still belongs to the retiring instruction here
        w_load_valid_o = ~we_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= m_addr_i[31:2];
        we_q    <= m_is_store_i;
        be_q    <= be_in;
        wdata_q <= wdata_in;
        size_q  <= m_size_i;
        uns_q   <= m_unsigned_i;
        off_q   <= m_addr_i[1:0];
      end
      if (capture_load) load_data_q <= load_proc;
    end
  end

  assign dmem_addr_o   = {addr_q, 2'b00};
  assign dmem_we_o     = we_q;
  assign dmem_be_o     = be_q;
  assign dmem_wdata_o  = wdata_q;
  assign w_load_data_o = load_data_q;

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: scoreboard bench for lsu_unit. The driver pushes expected
// requests/load results into queues; a monitor pops and compares whenever
// the DUT presents a request or a load-valid pulse.
module tb_lsu_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m_valid_i = 1'b0;
  logic        m_is_store_i = 1'b0;
  logic [1:0]  m_size_i = 2'b00;
  logic        m_unsigned_i = 1'b0;
  logic [31:0] m_addr_i = '0;
  logic [31:0] m_store_data_i = '0;
  logic        lsu_stall_o;
  logic        lsu_misaligned_o;
  logic        w_load_valid_o;
  logic [31:0] w_load_data_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  lsu_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_valid_i(m_valid_i), .m_is_store_i(m_is_store_i), .m_size_i(m_size_i),
    .m_unsigned_i(m_unsigned_i), .m_addr_i(m_addr_i), .m_store_data_i(m_store_data_i),
    .lsu_stall_o(lsu_stall_o), .lsu_misaligned_o(lsu_misaligned_o),
    .w_load_valid_o(w_load_valid_o), .w_load_data_o(w_load_data_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];

  int n_chk = 0;
  int n_fail = 0;

  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] next_rdata = '0;
  bit          resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Reference model: spec rules expressed as plain arithmetic
  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    int align;
    if (sz == 2'b11) return 1'b1;
    align = 1 << sz;
    return (a % align) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << sz;
    return 4'(((1 << nbytes) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int          bits;
    v = rd >> (8 * (a % 4));
    if (sz == 2'b10) return v;
    bits = (sz == 2'b00) ? 8 : 16;
    v = v & ((32'd1 << bits) - 1);
    if (!un && v[bits-1]) v = v - (32'd1 << bits);
    return v;
  endfunction

  // Memory responder: grant after gnt_dly cycles in REQ, rvalid rv_dly cycles after grant
  initial begin
    forever begin
      @(negedge clk_i iff (dmem_req_o && resp_en));
      repeat (gnt_dly) @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      repeat (rv_dly) @(negedge clk_i);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = next_rdata;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
    end
  end

  // Monitor: compare presented requests and load results against the queues
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_n_i) begin
        if (dmem_req_o) begin
          if (req_q.size() == 0) fail_evt("unexpected_req");
          else begin
            chk("req_addr", dmem_addr_o, req_q[0].addr);
            chk("req_we", 32'(dmem_we_o), 32'(req_q[0].we));
            chk("req_be", 32'(dmem_be_o), 32'(req_q[0].be));
            if (req_q[0].we) chk("req_wdata", dmem_wdata_o, req_q[0].wdata);
            if (dmem_gnt_i) void'(req_q.pop_front());
          end
        end
        if (w_load_valid_o) begin
          if (load_q.size() == 0) fail_evt("unexpected_load_valid");
          else chk("load_data", w_load_data_o, load_q.pop_front());
        end
      end
    end
  end

  // Present one instruction (called at negedge+2) and hold it until the stall drops
  task automatic do_op(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                       input int gd, input int rd);
    bit   mis;
    int   stalls;
    bit   done;
    req_t r;
    mis        = ref_mis(sz, a);
    gnt_dly    = gd;
    rv_dly     = rd;
    next_rdata = rdat;
    if (!mis) begin
      r.addr  = a & 32'hFFFF_FFFC;
      r.we    = st;
      r.be    = (sz == 2'b10) ? 4'hF : ref_be(sz, a);
      r.wdata = ref_wdata(sz, d);
      req_q.push_back(r);
      if (!st) load_q.push_back(ref_load(sz, un, a, rdat));
    end
    m_valid_i      = 1'b1;
    m_is_store_i   = st;
    m_size_i       = sz;
    m_unsigned_i   = un;
    m_addr_i       = a;
    m_store_data_i = d;
    stalls = 0;
    done   = 1'b0;
    #1;
    chk("misaligned", 32'(lsu_misaligned_o), 32'(mis));
    for (int c = 0; c < 100 && !done; c++) begin
      if (lsu_stall_o) begin
        stalls++;
        @(negedge clk_i);
        #3;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) fail_evt("stall_timeout");
    chk("stall_cycles", 32'(stalls), mis ? 32'd0 : 32'(3 + gd + rd));
    if (!mis && !st) chk("load_delivered", 32'(load_q.size()), 32'd0);
    @(negedge clk_i);
    #2;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    // Reset state
    #12;
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_lvalid", 32'(w_load_valid_o), 32'd0);
    chk("rst_ldata", w_load_data_o, 32'd0);
    chk("rst_stall", 32'(lsu_stall_o), 32'd0);
    chk("rst_mis", 32'(lsu_misaligned_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    #2;

    // Directed cases
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 3, 2);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 0, 0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 0, 0);
    do_op(1'b1, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        m_valid_i = 1'b0;
        #1;
        chk("idle_stall", 32'(lsu_stall_o), 32'd0);
        chk("idle_mis", 32'(lsu_misaligned_o), 32'd0);
        @(negedge clk_i);
        #2;
      end
    end

    // Reset while waiting for the response
    resp_en = 1'b0;
    req_q.push_back('{addr: 32'h0000_3000, we: 1'b0, be: 4'hF, wdata: 32'h0});
    m_valid_i = 1'b1; m_is_store_i = 1'b0; m_size_i = 2'b10; m_addr_i = 32'h0000_3000;
    @(negedge clk_i); #2;
    dmem_gnt_i = 1'b1;
    @(negedge clk_i); #2;
    dmem_gnt_i = 1'b0;
    chk("wait_stall", 32'(lsu_stall_o), 32'd1);
    m_valid_i = 1'b0;
    rst_n_i   = 1'b0;
    #1;
    req_q.delete();
    chk("mrst_req", 32'(dmem_req_o), 32'd0);
    chk("mrst_be", 32'(dmem_be_o), 32'd0);
    chk("mrst_addr", dmem_addr_o, 32'd0);
    chk("mrst_ldata", w_load_data_o, 32'd0);
    chk("mrst_stall", 32'(lsu_stall_o), 32'd0);
    @(negedge clk_i); #2;
    rst_n_i = 1'b1;
    @(negedge clk_i); #2;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk_i); #2;
    dmem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_lvalid", 32'(w_load_valid_o), 32'd0);
      chk("late_rvalid_stall", 32'(lsu_stall_o), 32'd0);
      @(negedge clk_i); #2;
    end
    resp_en = 1'b1;

    // Normal operation after the mid-transaction reset
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
